mpeg_burst_pacer: RTL and testbench

//  Paces a byte stream into the bhargava MPEG input port (mpeg_in/mpeg_in_en/stream_end).

---
 rtl/mpeg_burst_pacer.sv | 120 ++++++++++++
 tb/tb_mpeg_burst_pacer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mpeg_burst_pacer.sv
// Paces a valid/ready byte stream into the MPEG input port: every cfg_interval+1 cycles a pulse
// opens a burst of cfg_burst bytes. The output is registered one cycle after accept; mpeg_prog_full stalls with no loss.
module mpeg_burst_pacer #(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 7,
  parameter int BURST_W = 3,
  parameter int STAT_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [CNT_W-1:0]   cfg_interval,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic [DATA_W-1:0]  src_data,
  input  logic               src_valid,
  input  logic               src_last,
  output logic               src_ready,
  input  logic               mpeg_prog_full,
  output logic [DATA_W-1:0]  mpeg_in,
  output logic               mpeg_in_en,
  output logic               stream_end,
  output logic [STAT_W-1:0]  in_cnt,
  output logic [STAT_W-1:0]  down_time,
  output logic [STAT_W-1:0]  overrun_cnt
);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [BURST_W-1:0] burst_left, burst_left_nxt;
  logic               pulse;
  logic               accept;
  logic               ovr_inc;

  assign pulse = enable && (cnt == cfg_interval);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || pulse) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      burst_left <= '0;
    end else begin
      state      <= state_nxt;
      burst_left <= burst_left_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    burst_left_nxt = burst_left;
    src_ready      = 1'b0;
    accept         = 1'b0;
    ovr_inc        = 1'b0;
    case (state)
      IDLE: begin
        if (pulse && (cfg_burst != '0)) begin
          state_nxt      = BURST;
          burst_left_nxt = cfg_burst;
        end
      end
      BURST: begin
        src_ready = ~mpeg_prog_full;
        accept    = src_valid && ~mpeg_prog_full;
        if (accept && src_last) begin
          state_nxt      = DONE;
          burst_left_nxt = burst_left - BURST_W'(1);
          ovr_inc        = pulse && (burst_left != BURST_W'(1));
        end else if (accept && (burst_left == BURST_W'(1))) begin
          // A pulse landing exactly as the burst drains chains the next burst, not an overrun
          if (pulse && (cfg_burst != '0)) begin
            burst_left_nxt = cfg_burst;
          end else begin
            burst_left_nxt = '0;
            state_nxt      = IDLE;
          end
        end else begin
          if (accept) burst_left_nxt = burst_left - BURST_W'(1);
          ovr_inc = pulse;
        end
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mpeg_in     <= '0;
      mpeg_in_en  <= 1'b0;
      stream_end  <= 1'b0;
      in_cnt      <= '0;
      down_time   <= '0;
      overrun_cnt <= '0;
    end else begin
      mpeg_in_en <= accept;
      if (accept) begin
        mpeg_in <= src_data;
        if (in_cnt != '1) in_cnt <= in_cnt + STAT_W'(1);
      end
      if (accept && src_last) stream_end <= 1'b1;
      if (mpeg_prog_full && (down_time != '1)) down_time <= down_time + STAT_W'(1);
      if (ovr_inc && (overrun_cnt != '1)) overrun_cnt <= overrun_cnt + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_mpeg_burst_pacer.sv
// Scoreboard bench for mpeg_burst_pacer: accepted bytes are queued, popped on mpeg_in_en.
module tb_mpeg_burst_pacer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [6:0]  cfg_interval;
  logic [2:0]  cfg_burst;
  logic [7:0]  src_data;
  logic        src_valid;
  logic        src_last;
  logic        src_ready;
  logic        mpeg_prog_full;
  logic [7:0]  mpeg_in;
  logic        mpeg_in_en;
  logic        stream_end;
  logic [31:0] in_cnt;
  logic [31:0] down_time;
  logic [31:0] overrun_cnt;

  mpeg_burst_pacer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_interval(cfg_interval),
    .cfg_burst(cfg_burst), .src_data(src_data), .src_valid(src_valid),
    .src_last(src_last), .src_ready(src_ready), .mpeg_prog_full(mpeg_prog_full),
    .mpeg_in(mpeg_in), .mpeg_in_en(mpeg_in_en), .stream_end(stream_end),
    .in_cnt(in_cnt), .down_time(down_time), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         t0;
  int         src_idx, src_n, src_base;
  bit         src_on, last_en;
  int         rdy_cnt;
  logic [7:0] last_out;
  logic [7:0] exp_q[$];
  int         en_cyc[$];
  bit         en_se[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_src();
    src_valid = src_on && (src_idx < src_n);
    src_data  = 8'(src_base + src_idx);
    src_last  = last_en && (src_idx == src_n - 1);
  endtask

  task automatic tick();
    bit hs;
    @(negedge clk);
    if (mpeg_in_en) begin
      if (exp_q.size() == 0) check("extra_byte", 1, 0);
      else check("data", mpeg_in, exp_q.pop_front());
      last_out = mpeg_in;
      en_cyc.push_back(cyc);
      en_se.push_back(stream_end);
    end else begin
      check("hold", mpeg_in, last_out);
    end
    if (src_ready) rdy_cnt++;
    hs = src_valid && src_ready;
    if (hs) exp_q.push_back(src_data);
    @(posedge clk);
    #1;
    cyc++;
    if (hs) src_idx++;
    apply_src();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    enable = 1'b0;
    mpeg_prog_full = 1'b0;
    src_on = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    en_cyc.delete();
    en_se.delete();
    last_out = 8'h00;
    src_idx = 0;
    apply_src();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic start_stream(input int iv, input int bl, input int base, input int n, input bit lst);
    cfg_interval = 7'(iv);
    cfg_burst    = 3'(bl);
    src_base = base;
    src_n    = n;
    last_en  = lst;
    src_idx  = 0;
    src_on   = 1'b1;
    apply_src();
    t0 = cyc;
    enable = 1'b1;
  endtask

  task automatic check_en(input string tag, input int idx, input int exp_c);
    if (idx >= en_cyc.size()) check({tag, "_missing"}, idx, en_cyc.size());
    else check(tag, en_cyc[idx], exp_c);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; cfg_interval = '0; cfg_burst = '0;
    mpeg_prog_full = 1'b0; src_on = 1'b0; src_n = 0; src_base = 0; src_idx = 0;
    last_en = 1'b0; rdy_cnt = 0; last_out = 8'h00;
    apply_src();
    #2;
    check("rst_mpeg_in", mpeg_in, 0);
    check("rst_en", mpeg_in_en, 0);
    check("rst_stream_end", stream_end, 0);
    check("rst_in_cnt", in_cnt, 0);
    check("rst_down_time", down_time, 0);
    check("rst_overrun", overrun_cnt, 0);
    check("rst_src_ready", src_ready, 0);

    // 1: one byte every 128 cycles, last byte sets stream_end on the same strobe
    do_reset();
    start_stream(127, 1, 0, 10, 1'b1);
    run_to(t0 + 129 + 128 * 9 + 200);
    check("t1_count", en_cyc.size(), 10);
    for (int i = 0; i < 10; i++) check_en("t1_cycle", i, t0 + 129 + 128 * i);
    if (en_se.size() == 10) begin
      check("t1_se_before_last", en_se[8], 0);
      check("t1_se_with_last", en_se[9], 1);
    end else check("t1_se_count", en_se.size(), 10);
    check("t1_in_cnt", in_cnt, 10);
    check("t1_stream_end", stream_end, 1);
    check("t1_drain", exp_q.size(), 0);

    // 2: three groups of four, 16 cycles apart
    do_reset();
    start_stream(15, 4, 8'h40, 12, 1'b1);
    run_to(t0 + 70);
    check("t2_count", en_cyc.size(), 12);
    for (int g = 0; g < 3; g++)
      for (int i = 0; i < 4; i++) check_en("t2_cycle", g * 4 + i, t0 + 17 + 16 * g + i);
    check("t2_overrun", overrun_cnt, 0);
    check("t2_in_cnt", in_cnt, 12);
    check("t2_stream_end", stream_end, 1);
    check("t2_drain", exp_q.size(), 0);

    // 3: prog_full for 20 cycles after the second byte
    do_reset();
    start_stream(63, 4, 8'h80, 100, 1'b0);
    run_to(t0 + 66);
    mpeg_prog_full = 1'b1;
    repeat (20) tick();
    mpeg_prog_full = 1'b0;
    run_to(t0 + 100);
    check("t3_count", en_cyc.size(), 4);
    check_en("t3_b1", 0, t0 + 65);
    check_en("t3_b2", 1, t0 + 66);
    check_en("t3_b3", 2, t0 + 87);
    check_en("t3_b4", 3, t0 + 88);
    check("t3_down_time", down_time, 20);
    check("t3_in_cnt", in_cnt, 4);
    check("t3_stream_end", stream_end, 0);
    check("t3_drain", exp_q.size(), 0);

    // 4: burst longer than the interval -> one overrun per burst
    do_reset();
    start_stream(3, 7, 8'h10, 200, 1'b0);
    run_to(t0 + 44);
    check("t4_overrun", overrun_cnt, 5);
    check("t4_in_cnt", in_cnt, 35);

    // 4b: pulse coinciding with the final byte chains bursts back to back
    do_reset();
    start_stream(3, 4, 8'h20, 200, 1'b0);
    run_to(t0 + 30);
    check("t4b_overrun", overrun_cnt, 0);
    check("t4b_in_cnt", in_cnt, 26);
    check("t4b_first", en_cyc.size() > 0 ? en_cyc[0] : -1, t0 + 5);
    check("t4b_gapfree", en_cyc.size() > 0 ? en_cyc[en_cyc.size()-1] - en_cyc[0] + 1 : -1,
          en_cyc.size());

    // 5: source bubble mid-burst, then cfg_burst=0 keeps the pacer silent
    do_reset();
    start_stream(63, 4, 8'hC0, 100, 1'b0);
    run_to(t0 + 66);
    src_on = 1'b0; apply_src();
    repeat (5) tick();
    src_on = 1'b1; apply_src();
    run_to(t0 + 80);
    check("t5_count", en_cyc.size(), 4);
    check_en("t5_b2", 1, t0 + 66);
    check_en("t5_b3", 2, t0 + 72);
    check_en("t5_b4", 3, t0 + 73);
    cfg_burst = 3'd0;
    rdy_cnt = 0;
    repeat (500) tick();
    check("t5_idle_count", en_cyc.size(), 4);
    check("t5_idle_ready", rdy_cnt, 0);
    check("t5_in_cnt", in_cnt, 4);

    // 6: async reset mid-burst, restart timing from release
    do_reset();
    start_stream(15, 4, 8'h60, 100, 1'b0);
    mpeg_prog_full = 1'b1;
    tick();
    mpeg_prog_full = 1'b0;
    run_to(t0 + 18);
    check("t6_pre_in_cnt", in_cnt, 2);
    rst_n = 1'b0;
    #1;
    check("t6_mpeg_in", mpeg_in, 0);
    check("t6_en", mpeg_in_en, 0);
    check("t6_stream_end", stream_end, 0);
    check("t6_in_cnt", in_cnt, 0);
    check("t6_down_time", down_time, 0);
    check("t6_overrun", overrun_cnt, 0);
    exp_q.delete();
    en_cyc.delete();
    en_se.delete();
    last_out = 8'h00;
    repeat (2) tick();
    rst_n = 1'b1;
    t0 = cyc;
    run_to(t0 + 30);
    check_en("t6_first_after", 0, t0 + 17);
    check("t6_count", en_cyc.size(), 4);
    check("t6_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
